// File: rtl/svga_timing_detector.sv
// SVGA timing detector: measures incoming sync/blank geometry, qualifies it over several
// frames, and regenerates active-area pixel/line coordinates plus a data enable.
module svga_timing_detector #(
  parameter int unsigned H_W         = 12,
  parameter int unsigned V_W         = 11,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned H_TIMEOUT   = 4095
) (
  input  logic           pixel_clock,
  input  logic           reset,
  input  logic           h_synch_in,
  input  logic           v_synch_in,
  input  logic           blank_in,
  output logic [H_W-1:0] h_total,
  output logic [H_W-1:0] h_active,
  output logic [V_W-1:0] v_total,
  output logic [V_W-1:0] v_active,
  output logic [H_W-1:0] pixel_x,
  output logic [V_W-1:0] line_y,
  output logic           de,
  output logic           frame_start,
  output logic           locked,
  output logic           timing_error
);

  localparam int unsigned MW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StMeasure = 2'd1;
  localparam logic [1:0] StVerify  = 2'd2;
  localparam logic [1:0] StLocked  = 2'd3;

  localparam logic [H_W-1:0] TimeoutMax = H_W'(H_TIMEOUT);
  localparam logic [H_W-1:0] TimeoutM1  = H_W'(H_TIMEOUT - 1);
  localparam logic [MW-1:0]  LockCnt    = MW'(LOCK_FRAMES);

  // Input edge registers
  logic h_prev_q, v_prev_q, b_prev_q;
  logic h_rise, v_rise, line_active, timeout;

  // Free-running measurement counters and their latched results
  logic [H_W-1:0] hcnt_q, hcnt_d, act_cnt_q, act_cnt_d;
  logic [V_W-1:0] vcnt_q, vcnt_d, vact_cnt_q, vact_cnt_d, vcnt_inc, vact_inc;
  logic [H_W-1:0] h_meas_q, h_meas_d, h_act_meas_q, h_act_meas_d;
  logic [V_W-1:0] v_meas_q, v_meas_d, v_act_meas_q, v_act_meas_d;

  // Frame geometry snapshot used for stability qualification
  logic [H_W-1:0] snap_h_q, snap_ha_q;
  logic [V_W-1:0] snap_v_q, snap_va_q;
  logic           snap_eq, snap_load;

  logic [1:0]    state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic          locked_d, err_d, load_out;

  assign h_rise      = h_synch_in & ~h_prev_q;
  assign v_rise      = v_synch_in & ~v_prev_q;
  assign line_active = (act_cnt_q != '0);
  // Fires on the cycle hcnt would reach H_TIMEOUT and keeps firing while saturated
  assign timeout     = ~h_rise & (hcnt_q >= TimeoutM1);

  // Next-state of the line/frame measurement counters; a coincident h rise belongs to the
  // frame that the v rise closes
  always_comb begin
    hcnt_d = hcnt_q;
    if (h_rise) begin
      hcnt_d = '0;
    end else if (hcnt_q != TimeoutMax) begin
      hcnt_d = hcnt_q + H_W'(1);
    end

    act_cnt_d = act_cnt_q;
    if (h_rise) begin
      act_cnt_d = '0;
    end else if (!blank_in) begin
      act_cnt_d = act_cnt_q + H_W'(1);
    end

    vcnt_inc     = vcnt_q + V_W'(h_rise);
    vact_inc     = vact_cnt_q + V_W'(h_rise & line_active);
    vcnt_d       = v_rise ? '0 : vcnt_inc;
    vact_cnt_d   = v_rise ? '0 : vact_inc;

    h_meas_d     = h_rise ? (hcnt_q + H_W'(1)) : h_meas_q;
    h_act_meas_d = (h_rise && line_active) ? act_cnt_q : h_act_meas_q;
    v_meas_d     = v_rise ? vcnt_inc : v_meas_q;
    v_act_meas_d = v_rise ? vact_inc : v_act_meas_q;
  end

  assign snap_eq = (snap_h_q == h_meas_d) && (snap_ha_q == h_act_meas_d) &&
                   (snap_v_q == v_meas_d) && (snap_va_q == v_act_meas_d);

  // Lock qualification FSM; only v rises advance it, timeout overrides everything
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    locked_d  = locked;
    err_d     = 1'b0;
    snap_load = 1'b0;
    load_out  = 1'b0;
    if (timeout) begin
      state_d  = StSearch;
      match_d  = '0;
      locked_d = 1'b0;
      err_d    = (state_q == StLocked);
    end else if (v_rise) begin
      case (state_q)
        StSearch: state_d = StMeasure;
        StMeasure: begin
          snap_load = 1'b1;
          match_d   = '0;
          state_d   = StVerify;
        end
        StVerify: begin
          if (snap_eq) begin
            if (match_q + MW'(1) == LockCnt) begin
              match_d  = '0;
              state_d  = StLocked;
              locked_d = 1'b1;
              load_out = 1'b1;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            snap_load = 1'b1;
            match_d   = '0;
          end
        end
        StLocked: begin
          if (!snap_eq) begin
            err_d     = 1'b1;
            locked_d  = 1'b0;
            snap_load = 1'b1;
            match_d   = '0;
            state_d   = StVerify;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  // Edge registers, counters, measurements, snapshot and FSM state
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_prev_q     <= 1'b0;
      v_prev_q     <= 1'b0;
      b_prev_q     <= 1'b0;
      hcnt_q       <= '0;
      act_cnt_q    <= '0;
      vcnt_q       <= '0;
      vact_cnt_q   <= '0;
      h_meas_q     <= '0;
      h_act_meas_q <= '0;
      v_meas_q     <= '0;
      v_act_meas_q <= '0;
      snap_h_q     <= '0;
      snap_ha_q    <= '0;
      snap_v_q     <= '0;
      snap_va_q    <= '0;
      state_q      <= StSearch;
      match_q      <= '0;
    end else begin
      h_prev_q     <= h_synch_in;
      v_prev_q     <= v_synch_in;
      b_prev_q     <= blank_in;
      hcnt_q       <= hcnt_d;
      act_cnt_q    <= act_cnt_d;
      vcnt_q       <= vcnt_d;
      vact_cnt_q   <= vact_cnt_d;
      h_meas_q     <= h_meas_d;
      h_act_meas_q <= h_act_meas_d;
      v_meas_q     <= v_meas_d;
      v_act_meas_q <= v_act_meas_d;
      if (snap_load) begin
        snap_h_q  <= h_meas_d;
        snap_ha_q <= h_act_meas_d;
        snap_v_q  <= v_meas_d;
        snap_va_q <= v_act_meas_d;
      end
      state_q      <= state_d;
      match_q      <= match_d;
    end
  end

  // Registered outputs: geometry holds its last locked value until reset
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_total      <= '0;
      h_active     <= '0;
      v_total      <= '0;
      v_active     <= '0;
      pixel_x      <= '0;
      line_y       <= '0;
      de           <= 1'b0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      if (load_out) begin
        h_total  <= h_meas_d;
        h_active <= h_act_meas_d;
        v_total  <= v_meas_d;
        v_active <= v_act_meas_d;
      end
      if (!blank_in) begin
        pixel_x <= b_prev_q ? '0 : (pixel_x + H_W'(1));
      end
      if (v_rise) begin
        line_y <= '0;
      end else if (h_rise && line_active) begin
        line_y <= line_y + V_W'(1);
      end
      de           <= ~blank_in & locked;
      frame_start  <= v_rise;
      locked       <= locked_d;
      timing_error <= err_d;
    end
  end

endmodule

// File: tb/tb_svga_timing_detector.sv
// Directed bench for svga_timing_detector using a scaled-down raster:
// 40 cycles/line (32 active, hsync cols 34..37), 25 lines/frame (20 active, vsync lines 21..22).
module tb_svga_timing_detector;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        h_synch_in = 1'b0;
  logic        v_synch_in = 1'b0;
  logic        blank_in = 1'b1;
  logic [11:0] h_total, h_active, pixel_x;
  logic [10:0] v_total, v_active, line_y;
  logic        de, frame_start, locked, timing_error;

  int checks = 0;
  int failures = 0;
  int cur_line = 99, cur_col = 0;
  int de_cnt = 0, err_cnt = 0, fs_cnt = 0;
  int lock_line = -1, lock_col = -1;
  logic lock_prev = 1'b0;
  int px_first = -1, px_last = -1, ly_first = -1, ly_last = -1;

  svga_timing_detector dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .h_synch_in  (h_synch_in),
    .v_synch_in  (v_synch_in),
    .blank_in    (blank_in),
    .h_total     (h_total),
    .h_active    (h_active),
    .v_total     (v_total),
    .v_active    (v_active),
    .pixel_x     (pixel_x),
    .line_y      (line_y),
    .de          (de),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_error(timing_error)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge
  task automatic tick(input logic h, input logic v, input logic b);
    h_synch_in = h;
    v_synch_in = v;
    blank_in   = b;
    @(posedge pixel_clock);
    #1;
    if (de) de_cnt++;
    if (timing_error) err_cnt++;
    if (frame_start) fs_cnt++;
    if (locked && !lock_prev) begin
      lock_line = cur_line;
      lock_col  = cur_col;
    end
    lock_prev = locked;
    if (cur_line == 0 && cur_col == 0) begin
      px_first = int'(pixel_x);
      ly_first = int'(line_y);
    end
    if (cur_line == 19 && cur_col == 31) begin
      px_last = int'(pixel_x);
      ly_last = int'(line_y);
    end
  endtask

  task automatic drive_line(input int htot, input int line, input bit coinc);
    logic h, v, b;
    for (int c = 0; c < htot; c++) begin
      cur_line = line;
      cur_col  = c;
      b = !(line < 20 && c < 32);
      h = (c >= 34 && c < 38);
      if (coinc) v = (line == 21 && c >= 34) || line == 22 || (line == 23 && c < 34);
      else       v = (line == 21 || line == 22);
      tick(h, v, b);
    end
  endtask

  task automatic drive_frame(input int htot, input int first_line, input bit coinc);
    for (int l = first_line; l < 25; l++) drive_line(htot, l, coinc);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_h_total"}, int'(h_total), 0);
    check_eq({pfx, "_h_active"}, int'(h_active), 0);
    check_eq({pfx, "_v_total"}, int'(v_total), 0);
    check_eq({pfx, "_v_active"}, int'(v_active), 0);
    check_eq({pfx, "_pixel_x"}, int'(pixel_x), 0);
    check_eq({pfx, "_line_y"}, int'(line_y), 0);
    check_eq({pfx, "_de"}, int'(de), 0);
    check_eq({pfx, "_frame_start"}, int'(frame_start), 0);
    check_eq({pfx, "_locked"}, int'(locked), 0);
    check_eq({pfx, "_timing_error"}, int'(timing_error), 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check_all_zero("rst");
    reset = 1'b0;

    // 1: lock on the 5th v rise, one cycle after it is sampled
    for (int f = 1; f <= 4; f++) drive_frame(40, 0, 1'b0);
    check_eq("t1_unlocked_f4", int'(locked), 0);
    drive_frame(40, 0, 1'b0);
    check_eq("t1_locked_f5", int'(locked), 1);
    check_eq("t1_lock_line", lock_line, 21);
    check_eq("t1_lock_col", lock_col, 0);
    check_eq("t1_h_total", int'(h_total), 40);
    check_eq("t1_h_active", int'(h_active), 32);
    check_eq("t1_v_total", int'(v_total), 25);
    check_eq("t1_v_active", int'(v_active), 20);

    // 2: coordinates and data enable over one locked frame
    de_cnt = 0; err_cnt = 0; fs_cnt = 0;
    drive_frame(40, 0, 1'b0);
    check_eq("t2_px_first", px_first, 0);
    check_eq("t2_px_last", px_last, 31);
    check_eq("t2_ly_first", ly_first, 0);
    check_eq("t2_ly_last", ly_last, 19);
    check_eq("t2_de_count", de_cnt, 640);
    check_eq("t2_no_error", err_cnt, 0);
    check_eq("t2_frame_start", fs_cnt, 1);

    // 3: one longer-line frame breaks lock, steady long lines relock
    err_cnt = 0;
    drive_frame(41, 0, 1'b0);
    check_eq("t3_error_pulses", err_cnt, 1);
    check_eq("t3_unlocked", int'(locked), 0);
    check_eq("t3_h_total_held", int'(h_total), 40);
    drive_frame(41, 0, 1'b0);
    drive_frame(41, 0, 1'b0);
    check_eq("t3_unlocked_3rd", int'(locked), 0);
    drive_frame(41, 0, 1'b0);
    check_eq("t3_relocked", int'(locked), 1);
    check_eq("t3_h_total_new", int'(h_total), 41);
    check_eq("t3_error_total", err_cnt, 1);

    // 4: h_synch stops; timeout exactly H_TIMEOUT cycles after the last h rise
    cur_line = 99;
    err_cnt = 0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check_eq("t4_locked_before", int'(locked), 1);
    n = 0;
    while (n < 5000) begin
      tick(1'b0, 1'b0, 1'b1);
      n++;
      if (timing_error) break;
    end
    check_eq("t4_timeout_cycles", n, 4095);
    check_eq("t4_unlocked", int'(locked), 0);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    check_eq("t4_single_pulse", err_cnt, 1);
    check_eq("t4_h_total_held", int'(h_total), 41);

    // 5: relock, then reset mid-line and relock from scratch
    for (int f = 1; f <= 5; f++) drive_frame(40, 0, 1'b0);
    check_eq("t5_locked_pre", int'(locked), 1);
    for (int l = 0; l < 10; l++) drive_line(40, l, 1'b0);
    cur_line = 10;
    for (int c = 0; c < 5; c++) begin
      cur_col = c;
      tick(1'b0, 1'b0, 1'b0);
    end
    check_eq("t5_px_pre_reset", int'(pixel_x), 4);
    check_eq("t5_de_pre_reset", int'(de), 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t5_async");
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    drive_frame(40, 10, 1'b0);
    for (int f = 2; f <= 4; f++) drive_frame(40, 0, 1'b0);
    check_eq("t5_unlocked_4th", int'(locked), 0);
    drive_frame(40, 0, 1'b0);
    check_eq("t5_relocked_5th", int'(locked), 1);
    check_eq("t5_h_total", int'(h_total), 40);

    // 6: h and v rise together; the coincident line counts toward v_total
    err_cnt = 0; fs_cnt = 0;
    drive_frame(40, 0, 1'b1);
    check_eq("t6_shift_error", err_cnt, 1);
    for (int f = 2; f <= 4; f++) drive_frame(40, 0, 1'b1);
    check_eq("t6_unlocked_4th", int'(locked), 0);
    drive_frame(40, 0, 1'b1);
    check_eq("t6_locked", int'(locked), 1);
    check_eq("t6_v_total", int'(v_total), 25);
    check_eq("t6_v_active", int'(v_active), 20);
    check_eq("t6_frame_starts", fs_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
